// File: rtl/uc_sample_bridge.sv
// uc_sample_bridge: CPU-side sample buffering between the rx/tx channels and the CSR bank.
// The capture FIFO stores downsampled rx I/Q words for the CPU, with a show-ahead read.
// The playback FIFO stores CPU-written I/Q words and plays them out on the ce_down strobe.
module uc_sample_bridge #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 ce_down,
    input  logic signed [DW-1:0] rx_x,
    input  logic signed [DW-1:0] rx_y,
    input  logic                 cap_en,
    input  logic                 rx_flush,
    input  logic                 rd_en,
    output logic [2*DW-1:0]      rd_data,
    output logic                 rd_valid,
    output logic [AW:0]          rx_level,
    output logic                 rx_overflow,
    input  logic                 clr_rx_ovf,
    input  logic                 wr_en,
    input  logic [2*DW-1:0]      wr_data,
    input  logic                 play_en,
    input  logic                 tx_flush,
    output logic [AW:0]          tx_level,
    output logic                 tx_full,
    output logic signed [DW-1:0] tx_x,
    output logic signed [DW-1:0] tx_y,
    output logic                 tx_underflow,
    input  logic                 clr_tx_unf
);

    localparam int DEPTH = 1 << AW;

    logic [2*DW-1:0] r_rx_mem [DEPTH];
    logic [2*DW-1:0] r_tx_mem [DEPTH];
    logic [AW:0]     r_rx_wp, r_rx_rp, r_rx_level;
    logic [AW:0]     r_tx_wp, r_tx_rp, r_tx_level;
    logic            r_rx_ovf, r_tx_unf;
    logic [2*DW-1:0] r_tx_out;

    logic w_rx_empty, w_rx_full, w_rx_req, w_rx_push, w_rx_pop, w_rx_drop;
    logic w_tx_empty, w_tx_full, w_tx_strobe, w_tx_push, w_tx_pop, w_tx_unf;

    // Full when the wrap bits differ but the addresses match; empty when the pointers are equal.
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp == {~r_rx_rp[AW], r_rx_rp[AW-1:0]});
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp == {~r_tx_rp[AW], r_tx_rp[AW-1:0]});

    // Flush wins over any push or pop in the same cycle, and a flushed push is not an overflow.
    assign w_rx_req  = ce_down & cap_en;
    assign w_rx_pop  = rd_en & ~w_rx_empty & ~rx_flush;
    assign w_rx_push = w_rx_req & ~rx_flush & (~w_rx_full | w_rx_pop);
    assign w_rx_drop = w_rx_req & ~rx_flush & w_rx_full & ~w_rx_pop;

    assign w_tx_strobe = ce_down & play_en;
    assign w_tx_pop    = w_tx_strobe & ~w_tx_empty & ~tx_flush;
    assign w_tx_push   = wr_en & ~tx_flush & (~w_tx_full | w_tx_pop);
    assign w_tx_unf    = w_tx_strobe & w_tx_empty;

    // Show-ahead head word; forced to zero while empty so the port reads 0 out of reset.
    assign rd_data      = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[AW-1:0]];
    assign rd_valid     = ~w_rx_empty;
    assign rx_level     = r_rx_level;
    assign rx_overflow  = r_rx_ovf;
    assign tx_level     = r_tx_level;
    assign tx_full      = w_tx_full;
    assign tx_x         = r_tx_out[2*DW-1:DW];
    assign tx_y         = r_tx_out[DW-1:0];
    assign tx_underflow = r_tx_unf;

    // Capture storage write port (no reset on sample storage).
    always_ff @(posedge sys_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= {rx_x, rx_y};
    end

    // Playback storage write port (no reset on sample storage).
    always_ff @(posedge sys_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= wr_data;
    end

    // Capture pointers, level and sticky overflow; a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_level <= '0;
            r_rx_ovf   <= 1'b0;
        end else begin
            if (rx_flush) begin
                r_rx_wp    <= '0;
                r_rx_rp    <= '0;
                r_rx_level <= '0;
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
                r_rx_level <= r_rx_level + (AW+1)'(w_rx_push) - (AW+1)'(w_rx_pop);
            end
            if (w_rx_drop)       r_rx_ovf <= 1'b1;
            else if (clr_rx_ovf) r_rx_ovf <= 1'b0;
        end
    end

    // Playback pointers, level, output sample and sticky underflow; tx_flush leaves the output alone.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_level <= '0;
            r_tx_unf   <= 1'b0;
            r_tx_out   <= '0;
        end else begin
            if (tx_flush) begin
                r_tx_wp    <= '0;
                r_tx_rp    <= '0;
                r_tx_level <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
                r_tx_level <= r_tx_level + (AW+1)'(w_tx_push) - (AW+1)'(w_tx_pop);
            end
            if (w_tx_pop) r_tx_out <= r_tx_mem[r_tx_rp[AW-1:0]];
            if (w_tx_unf)        r_tx_unf <= 1'b1;
            else if (clr_tx_unf) r_tx_unf <= 1'b0;
        end
    end

endmodule
